// File: rtl/rv32i_dmem_arbiter.sv
// Round-robin arbiter that shares the RAM data port between the core LSU (port 0)
// and the debug/program loader (port 1), with alignment checks and lane steering.
module rv32i_dmem_arbiter #(
   parameter int MEM_BYTES = 4096,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [1:0]        width0,
   input  logic [1:0]        width1,
   input  logic              sign0,
   input  logic              sign1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [31:0]       rdata0,
   output logic [31:0]       rdata1,
   output logic              err0,
   output logic              err1,
   output logic [ADDR_W-1:0] d_addr,
   output logic              d_we,
   output logic [3:0]        d_be,
   output logic [31:0]       d_wdata,
   input  logic [31:0]       d_rdata
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t              state;
   logic                last_grant;
   logic                own_q;
   logic                we_q;
   logic                err_q;
   logic                sign_q;
   logic [1:0]          width_q;
   logic [1:0]          b_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         rdata0_q;
   logic [31:0]         rdata1_q;

   logic                can_grant;
   logic                grant;
   logic                sel;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [1:0]          sel_width;
   logic                sel_sign;
   logic [31:0]         sel_wdata;
   logic [1:0]          sel_b;
   logic                sel_err;
   logic [3:0]          lane_mask;
   logic [31:0]         shifted;
   logic [31:0]         load_val;

   // On a tie the port that did not win last time is granted.
   assign can_grant = !reset && (state == IDLE);
   assign gnt0      = can_grant && req0 && (!req1 || last_grant);
   assign gnt1      = can_grant && req1 && (!req0 || !last_grant);
   assign grant     = gnt0 || gnt1;
   assign sel       = gnt1;

   assign sel_we    = sel ? we1    : we0;
   assign sel_addr  = sel ? addr1  : addr0;
   assign sel_width = sel ? width1 : width0;
   assign sel_sign  = sel ? sign1  : sign0;
   assign sel_wdata = sel ? wdata1 : wdata0;
   assign sel_b     = sel_addr[1:0];

   assign sel_err = (sel_width == 2'b11)
                 || ((sel_width == 2'b01) && sel_b[0])
                 || ((sel_width == 2'b10) && (sel_b != 2'b00))
                 || (sel_addr >= ADDR_W'(MEM_BYTES));

   always_comb begin
      lane_mask = 4'b1111;
      case (sel_width)
         2'b00:   lane_mask = 4'b0001 << sel_b;
         2'b01:   lane_mask = 4'b0011 << sel_b;
         default: lane_mask = 4'b1111;
      endcase
   end

   // Rejected accesses and loads never touch the RAM lanes.
   assign d_we    = grant && sel_we && !sel_err;
   assign d_be    = d_we ? lane_mask : 4'b0000;
   assign d_wdata = grant ? (sel_wdata << {sel_b, 3'b000}) : 32'd0;
   assign d_addr  = grant ? sel_addr : addr_q;

   assign shifted = d_rdata >> {b_q, 3'b000};

   always_comb begin
      load_val = shifted;
      case (width_q)
         2'b00:   load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   // Read data is live during the response cycle and held afterwards.
   always_comb begin
      rdata0 = rdata0_q;
      rdata1 = rdata1_q;
      if (state == RESP) begin
         if (!own_q) begin
            rdata0 = err_q ? 32'd0 : (we_q ? rdata0_q : load_val);
         end else begin
            rdata1 = err_q ? 32'd0 : (we_q ? rdata1_q : load_val);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         own_q      <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         sign_q     <= 1'b0;
         width_q    <= 2'b00;
         b_q        <= 2'b00;
         addr_q     <= '0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0_q   <= 32'd0;
         rdata1_q   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               rvalid0 <= 1'b0;
               rvalid1 <= 1'b0;
               err0    <= 1'b0;
               err1    <= 1'b0;
               if (grant) begin
                  state      <= RESP;
                  last_grant <= sel;
                  own_q      <= sel;
                  we_q       <= sel_we;
                  err_q      <= sel_err;
                  sign_q     <= sel_sign;
                  width_q    <= sel_width;
                  b_q        <= sel_b;
                  addr_q     <= sel_addr;
                  rvalid0    <= !sel;
                  rvalid1    <= sel;
                  err0       <= !sel && sel_err;
                  err1       <= sel && sel_err;
               end
            end
            RESP: begin
               state    <= IDLE;
               rvalid0  <= 1'b0;
               rvalid1  <= 1'b0;
               err0     <= 1'b0;
               err1     <= 1'b0;
               rdata0_q <= rdata0;
               rdata1_q <= rdata1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// Self-checking bench for rv32i_dmem_arbiter: a byte-array RAM harness plus a
// byte-level reference model of the loads, stores and error rules.
module tb_rv32i_dmem_arbiter;

   localparam int MEM_BYTES = 4096;

   logic        clk;
   logic        reset;
   logic        req0, req1, we0, we1, sign0, sign1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  width0, width1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] d_addr;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;

   int errors = 0;
   int checks = 0;

   logic [7:0]  ram     [0:MEM_BYTES-1];
   logic [7:0]  ref_mem [0:MEM_BYTES-1];
   logic [31:0] model_rdata [0:1];
   logic        load_ram;

   typedef struct packed {
      logic        timeout;
      logic        d_we;
      logic [3:0]  d_be;
      logic [31:0] d_wdata;
      logic        rvalid0;
      logic        rvalid1;
      logic        err0;
      logic        err1;
      logic [31:0] rdata0;
      logic [31:0] rdata1;
   } obs_t;

   rv32i_dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .width0(width0), .width1(width1),
      .sign0(sign0), .sign1(sign1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
      .d_rdata(d_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM harness: registered read, byte-lane write.
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < MEM_BYTES; i++) ram[i] <= ref_mem[i];
      end else if (d_we) begin
         for (int i = 0; i < 4; i++)
            if (d_be[i]) ram[{d_addr[11:2], 2'(i)}] <= d_wdata[8*i +: 8];
      end
      d_rdata <= {ram[{d_addr[11:2], 2'd3}], ram[{d_addr[11:2], 2'd2}],
                  ram[{d_addr[11:2], 2'd1}], ram[{d_addr[11:2], 2'd0}]};
   end

   // Reference model: byte-addressed memory, little-endian, arithmetic extension.
   task automatic model_access(input int port, input logic we, input logic [31:0] addr,
                               input logic [1:0] width, input logic sgn, input logic [31:0] wdata,
                               output logic e_err, output logic [3:0] e_be, output logic e_we,
                               output logic [31:0] e_wdata, output logic [31:0] e_rdata);
      int nbytes;
      int off;
      logic [63:0] v;
      nbytes  = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
      off     = int'(addr % 4);
      e_err   = (width == 2'd3) || ((addr % nbytes) != 0) || (addr >= 32'(MEM_BYTES));
      e_be    = 4'b0000;
      e_we    = 1'b0;
      e_wdata = wdata << (8 * off);
      if (e_err) begin
         e_rdata = 32'd0;
         model_rdata[port] = 32'd0;
      end else if (we) begin
         e_we = 1'b1;
         for (int i = 0; i < nbytes; i++) begin
            e_be = e_be | (4'b0001 << (off + i));
            ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
         end
         e_rdata = model_rdata[port];
      end else begin
         v = 64'd0;
         for (int i = 0; i < nbytes; i++) v = v | (64'(ref_mem[addr + 32'(i)]) << (8 * i));
         if (sgn && v[8*nbytes-1]) v = v - (64'd1 << (8 * nbytes));
         e_rdata = v[31:0];
         model_rdata[port] = e_rdata;
      end
   endtask

   // Drive one request, wait (bounded) for its grant, then capture the response cycle.
   task automatic access(input int port, input logic we, input logic [31:0] addr,
                         input logic [1:0] width, input logic sgn, input logic [31:0] wdata,
                         output obs_t o);
      int n;
      if (port == 0) begin
         req0 = 1'b1; we0 = we; addr0 = addr; width0 = width; sign0 = sgn; wdata0 = wdata;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; width1 = width; sign1 = sgn; wdata1 = wdata;
      end
      #1;
      n = 0;
      while (!((port == 0) ? gnt0 : gnt1) && n < 6) begin
         @(negedge clk); #1;
         n++;
      end
      o.timeout = (n >= 6);
      o.d_we    = d_we;
      o.d_be    = d_be;
      o.d_wdata = d_wdata;
      @(negedge clk); #1;
      o.rvalid0 = rvalid0; o.rvalid1 = rvalid1;
      o.err0    = err0;    o.err1    = err1;
      o.rdata0  = rdata0;  o.rdata1  = rdata1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; load_ram = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; width0 = 2'd2; wdata0 = 32'hdeadbeef;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
      checks++; if (d_we !== 1'b0) begin errors++; $display("FAIL reset_d_we got=%b exp=0", d_we); end
      checks++; if (d_be !== 4'b0000) begin errors++; $display("FAIL reset_d_be got=%b exp=0000", d_be); end
      checks++; if ({rvalid0, rvalid1, err0, err1} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {rvalid0, rvalid1, err0, err1}); end
      checks++; if ({rdata0, rdata1} !== 64'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {rdata0, rdata1}); end
      req0 = 1'b0; load_ram = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if ({gnt0, gnt1, d_we, d_be} !== 7'd0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", {gnt0, gnt1, d_we, d_be}); end
   endtask

   task automatic test_byte_store_load();
      obs_t o;
      logic e_err, e_we;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_rd;
      access(0, 1'b1, 32'h3, 2'd0, 1'b0, 32'h80, o);
      model_access(0, 1'b1, 32'h3, 2'd0, 1'b0, 32'h80, e_err, e_be, e_we, e_wd, e_rd);
      checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL t1_store_gnt timeout=%b exp=0", o.timeout); end
      checks++; if (o.d_be !== 4'b1000) begin errors++; $display("FAIL t1_store_be got=%b exp=1000", o.d_be); end
      checks++; if (o.d_wdata !== 32'h80000000) begin errors++; $display("FAIL t1_store_wdata got=%h exp=80000000", o.d_wdata); end
      checks++; if ({o.d_we, o.rvalid0, o.err0} !== 3'b110) begin errors++; $display("FAIL t1_store_resp got=%b exp=110", {o.d_we, o.rvalid0, o.err0}); end
      access(0, 1'b0, 32'h3, 2'd0, 1'b0, 32'h0, o);
      model_access(0, 1'b0, 32'h3, 2'd0, 1'b0, 32'h0, e_err, e_be, e_we, e_wd, e_rd);
      checks++; if ({o.d_we, o.d_be} !== 5'd0) begin errors++; $display("FAIL t1_load_lanes got=%b exp=0", {o.d_we, o.d_be}); end
      checks++; if (o.rvalid0 !== 1'b1) begin errors++; $display("FAIL t1_load_rvalid got=%b exp=1", o.rvalid0); end
      checks++; if (o.rdata0 !== 32'h00000080) begin errors++; $display("FAIL t1_load_rdata got=%h exp=00000080", o.rdata0); end
   endtask

   task automatic test_half_sign();
      obs_t o;
      logic e_err, e_we;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_rd;
      access(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h12345678, o);
      model_access(0, 1'b1, 32'h0, 2'd2, 1'b0, 32'h12345678, e_err, e_be, e_we, e_wd, e_rd);
      checks++; if (o.d_be !== 4'b1111) begin errors++; $display("FAIL t2_word_be got=%b exp=1111", o.d_be); end
      access(0, 1'b0, 32'h2, 2'd1, 1'b1, 32'h0, o);
      model_access(0, 1'b0, 32'h2, 2'd1, 1'b1, 32'h0, e_err, e_be, e_we, e_wd, e_rd);
      checks++; if (o.rdata0 !== 32'h00001234) begin errors++; $display("FAIL t2_half_hi got=%h exp=00001234", o.rdata0); end
      access(0, 1'b1, 32'h0, 2'd1, 1'b0, 32'h0000fffb, o);
      model_access(0, 1'b1, 32'h0, 2'd1, 1'b0, 32'h0000fffb, e_err, e_be, e_we, e_wd, e_rd);
      checks++; if (o.d_be !== 4'b0011) begin errors++; $display("FAIL t2_half_be got=%b exp=0011", o.d_be); end
      checks++; if (o.rdata0 !== 32'h00001234) begin errors++; $display("FAIL t2_store_hold got=%h exp=00001234", o.rdata0); end
      access(0, 1'b0, 32'h0, 2'd1, 1'b1, 32'h0, o);
      model_access(0, 1'b0, 32'h0, 2'd1, 1'b1, 32'h0, e_err, e_be, e_we, e_wd, e_rd);
      checks++; if (o.rdata0 !== 32'hfffffffb) begin errors++; $display("FAIL t2_half_signed got=%h exp=fffffffb", o.rdata0); end
   endtask

   task automatic test_round_robin();
      logic e_err, e_we;
      logic [3:0] e_be;
      logic [31:0] e_wd;
      logic [31:0] exp_rd;
      int p;
      reset = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; width0 = 2'd2; sign0 = 1'b0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20; width1 = 2'd2; sign1 = 1'b0;
      model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
      exp_rd = 32'd0; p = 0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({gnt1, gnt0} !== {(k % 4) == 2, (k % 4) == 0}) begin
            errors++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", k, {gnt1, gnt0}, {(k % 4) == 2, (k % 4) == 0});
         end
         if (k % 2 == 0) begin
            p = (k % 4 == 0) ? 0 : 1;
            model_access(p, 1'b0, (p == 0) ? 32'h10 : 32'h20, 2'd2, 1'b0, 32'h0, e_err, e_be, e_we, e_wd, exp_rd);
            checks++; if ({rvalid1, rvalid0} !== 2'b00) begin errors++; $display("FAIL rr_idle_rvalid cycle=%0d got=%b exp=00", k, {rvalid1, rvalid0}); end
         end else begin
            checks++; if ({rvalid1, rvalid0} !== ((p == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_rvalid cycle=%0d got=%b exp=%b", k, {rvalid1, rvalid0}, (p == 0) ? 2'b01 : 2'b10); end
            checks++; if (((p == 0) ? rdata0 : rdata1) !== exp_rd) begin errors++; $display("FAIL rr_rdata cycle=%0d got=%h exp=%h", k, (p == 0) ? rdata0 : rdata1, exp_rd); end
         end
         @(negedge clk); #1;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_errors();
      obs_t o;
      logic e_err, e_we;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_rd;
      logic [31:0] a [4];
      logic [1:0]  w [4];
      logic        s [4];
      a = '{32'h1, 32'h2, 32'h0, 32'(MEM_BYTES)};
      w = '{2'd1, 2'd2, 2'd3, 2'd0};
      s = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         access(1, s[i], a[i], w[i], 1'b0, 32'ha5a5a5a5, o);
         model_access(1, s[i], a[i], w[i], 1'b0, 32'ha5a5a5a5, e_err, e_be, e_we, e_wd, e_rd);
         checks++; if ({o.err1, o.rvalid1} !== 2'b11) begin errors++; $display("FAIL err_flags case=%0d got=%b exp=11", i, {o.err1, o.rvalid1}); end
         checks++; if ({o.d_we, o.d_be} !== 5'd0) begin errors++; $display("FAIL err_lanes case=%0d got=%b exp=0", i, {o.d_we, o.d_be}); end
         checks++; if (o.rdata1 !== 32'd0) begin errors++; $display("FAIL err_rdata case=%0d got=%h exp=0", i, o.rdata1); end
         checks++; if ({o.rvalid0, o.err0} !== 2'b00) begin errors++; $display("FAIL err_other_port case=%0d got=%b exp=00", i, {o.rvalid0, o.err0}); end
      end
      for (int i = 0; i < 2; i++) begin
         access(0, 1'b0, 32'(4 * i), 2'd2, 1'b0, 32'h0, o);
         model_access(0, 1'b0, 32'(4 * i), 2'd2, 1'b0, 32'h0, e_err, e_be, e_we, e_wd, e_rd);
         checks++; if (o.rdata0 !== e_rd) begin errors++; $display("FAIL err_readback word=%0d got=%h exp=%h", i, o.rdata0, e_rd); end
      end
   endtask

   task automatic test_reset_mid_resp();
      logic e_err, e_we;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_rd;
      int n;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0; width1 = 2'd2; sign1 = 1'b0;
      #1;
      n = 0;
      while (!gnt1 && n < 6) begin
         @(negedge clk); #1;
         n++;
      end
      checks++; if (n >= 6) begin errors++; $display("FAIL midreset_gnt1 timeout got=%0d exp<6", n); end
      @(posedge clk); #1;
      reset = 1'b1;
      model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
      #1;
      checks++; if ({rvalid1, err1, gnt1} !== 3'b000) begin errors++; $display("FAIL midreset_pulse got=%b exp=000", {rvalid1, err1, gnt1}); end
      checks++; if ({rdata0, rdata1} !== 64'd0) begin errors++; $display("FAIL midreset_rdata got=%h exp=0", {rdata0, rdata1}); end
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4; width0 = 2'd2; sign0 = 1'b0;
      @(negedge clk); #1;
      checks++; if ({rvalid1, gnt0, gnt1} !== 3'b000) begin errors++; $display("FAIL midreset_hold got=%b exp=000", {rvalid1, gnt0, gnt1}); end
      reset = 1'b0;
      #1;
      checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL midreset_tie got=%b exp=10", {gnt0, gnt1}); end
      model_access(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0, e_err, e_be, e_we, e_wd, e_rd);
      @(negedge clk); #1;
      checks++; if ({rvalid0, rvalid1} !== 2'b10) begin errors++; $display("FAIL midreset_resp got=%b exp=10", {rvalid0, rvalid1}); end
      checks++; if (rdata0 !== e_rd) begin errors++; $display("FAIL midreset_rdata0 got=%h exp=%h", rdata0, e_rd); end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_random();
      obs_t o;
      logic e_err, e_we;
      logic [3:0] e_be;
      logic [31:0] e_wd, e_rd;
      int port;
      logic we, sgn;
      logic [31:0] addr, wd;
      logic [1:0] width;
      for (int i = 0; i < 60; i++) begin
         port  = int'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         sgn   = 1'($urandom_range(0, 1));
         width = 2'($urandom_range(0, 3));
         wd    = $urandom;
         addr  = ($urandom_range(0, 9) == 0) ? 32'(MEM_BYTES) + 32'($urandom_range(0, 7))
                                              : 32'($urandom_range(0, 63));
         access(port, we, addr, width, sgn, wd, o);
         model_access(port, we, addr, width, sgn, wd, e_err, e_be, e_we, e_wd, e_rd);
         checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL rnd_gnt it=%0d timeout=%b exp=0", i, o.timeout); end
         checks++; if (((port == 0) ? {o.rvalid0, o.err0} : {o.rvalid1, o.err1}) !== {1'b1, e_err}) begin errors++; $display("FAIL rnd_flags it=%0d got=%b exp=%b", i, (port == 0) ? {o.rvalid0, o.err0} : {o.rvalid1, o.err1}, {1'b1, e_err}); end
         checks++; if (((port == 0) ? {o.rvalid1, o.err1} : {o.rvalid0, o.err0}) !== 2'b00) begin errors++; $display("FAIL rnd_other it=%0d got=%b exp=00", i, (port == 0) ? {o.rvalid1, o.err1} : {o.rvalid0, o.err0}); end
         checks++; if ({o.d_we, o.d_be} !== {e_we, e_be}) begin errors++; $display("FAIL rnd_lanes it=%0d got=%b exp=%b", i, {o.d_we, o.d_be}, {e_we, e_be}); end
         if (e_we) begin
            checks++; if (o.d_wdata !== e_wd) begin errors++; $display("FAIL rnd_wdata it=%0d got=%h exp=%h", i, o.d_wdata, e_wd); end
         end
         checks++; if (((port == 0) ? o.rdata0 : o.rdata1) !== e_rd) begin errors++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", i, (port == 0) ? o.rdata0 : o.rdata1, e_rd); end
      end
   endtask

   initial begin
      reset = 1'b1; load_ram = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; sign0 = 1'b0; sign1 = 1'b0;
      addr0 = 32'd0; addr1 = 32'd0; width0 = 2'd0; width1 = 2'd0; wdata0 = 32'd0; wdata1 = 32'd0;
      model_rdata[0] = 32'd0; model_rdata[1] = 32'd0;
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
      test_reset();
      test_byte_store_load();
      test_half_sign();
      test_round_robin();
      test_errors();
      test_reset_mid_resp();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
